// File: rtl/spi_slave_top.sv
// spi_slave_top
// SPI responder exchanging fixed-length words with the processor through a
// 32-bit control / wrdata / rddata / status register set. Every SPI pin is
// brought into clk through a 2-FF synchroniser; nothing is clocked by sclk_i.
// sclk_i must be no faster than clk/8.
//
// Parameters:
//   CPOL  - idle level of sclk_i
//   CPHA  - 0: sample on leading edge, 1: sample on trailing edge
//   NBITS - frame length in bits (8..32), MSB first
//
// Ports:
//   clk      system clock (only clock)
//   reset    asynchronous active-low reset
//   control  [0] tx_load (rising edge), [1] clear_flags (rising edge)
//   wrdata   next transmit word, [NBITS-1:0] used
//   rddata   last complete received word, zero-extended
//   status   [31] busy  [30] rx_valid  [29] rx_overrun  [28] tx_underrun
//            [27] tx_pending  [26] frame_error  [15:8] bits in current frame
//            [7:0] completed-frame count
//   sclk_i, csn_i, mosi_i   asynchronous SPI inputs
//   miso_o   serial data out (registered)
//   miso_oe  pad output enable, high while a frame is active
//
// Optional feature: define SPI_SLAVE_ECHO_EN to transmit the last received
// word instead of zeros when no transmit word was loaded.
//
// Handshake: there is no valid/ready pair. tx_load and clear_flags are
// rising-edge commands; rx_valid stays set until clear_flags, and a frame
// that completes while rx_valid is set raises rx_overrun and replaces rddata.
module spi_slave_top #(
  parameter logic CPOL  = 1'b0,
  parameter logic CPHA  = 1'b0,
  parameter int   NBITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] control,
  input  logic [31:0] wrdata,
  output logic [31:0] rddata,
  output logic [31:0] status,
  input  logic        sclk_i,
  input  logic        csn_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam int         CW     = 6;

  logic [0:0]       state;
  logic             sclk_s1, sclk_s2, sclk_h;
  logic             csn_s1, csn_s2, csn_h;
  logic             mosi_s1, mosi_s2;
  logic [1:0]       ctrl_q, ctrl_h;
  logic [NBITS-1:0] tx_hold, tx_sr, rx_sr, rd_q, next_tx;
  logic [CW-1:0]    bit_cnt;
  logic [7:0]       frame_cnt;
  logic             rx_valid, rx_overrun, tx_underrun, tx_pending, frame_error;
  // Set when the next shift edge must re-drive the current MSB instead of
  // advancing: the first leading edge of a CPHA=1 frame, and the first shift
  // edge after a word completes under a continuing csn.
  logic             hold_msb;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic csn_fall, csn_rise, load_rise, clear_rise, active, frame_done;
  logic unused_bits;

  assign sclk_rise   = sclk_s2 & ~sclk_h;
  assign sclk_fall   = ~sclk_s2 & sclk_h;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign csn_fall    = ~csn_s2 & csn_h;
  assign csn_rise    = csn_s2 & ~csn_h;
  assign load_rise   = ctrl_q[0] & ~ctrl_h[0];
  assign clear_rise  = ctrl_q[1] & ~ctrl_h[1];
  assign active      = (state == ACTIVE);
  assign frame_done  = active && (bit_cnt == CW'(NBITS));
  assign unused_bits = ^{control[31:2], wrdata};

  // Word to shift out at a frame start or a back-to-back reload. At a reload
  // the freshly completed word is in rx_sr, not yet in rd_q.
  always_comb begin
    next_tx = '0;
    if (tx_pending) begin
      next_tx = tx_hold;
    end else begin
`ifdef SPI_SLAVE_ECHO_EN
      next_tx = frame_done ? rx_sr : rd_q;
`else
      next_tx = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_h      <= 1'b0;
      csn_s1      <= 1'b0;
      csn_s2      <= 1'b0;
      csn_h       <= 1'b0;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      ctrl_q      <= '0;
      ctrl_h      <= '0;
      tx_hold     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rd_q        <= '0;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      tx_pending  <= 1'b0;
      frame_error <= 1'b0;
      hold_msb    <= 1'b0;
      miso_o      <= 1'b0;
    end else begin
      sclk_s1 <= sclk_i;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      // csn syncs reset low, so a csn already low at reset release produces
      // no falling edge; a new frame needs csn to go high first.
      csn_s1  <= csn_i;
      csn_s2  <= csn_s1;
      csn_h   <= csn_s2;
      mosi_s1 <= mosi_i;
      mosi_s2 <= mosi_s1;
      ctrl_q  <= control[1:0];
      ctrl_h  <= ctrl_q;

      // Cleared first so that a flag set later in this block wins.
      if (clear_rise) begin
        rx_valid    <= 1'b0;
        rx_overrun  <= 1'b0;
        tx_underrun <= 1'b0;
        frame_error <= 1'b0;
      end

      if (state == IDLE) begin
        if (csn_fall) begin
          state    <= ACTIVE;
          bit_cnt  <= '0;
          tx_sr    <= next_tx;
          miso_o   <= next_tx[NBITS-1];
          hold_msb <= CPHA;
          if (tx_pending) tx_pending  <= 1'b0;
          else            tx_underrun <= 1'b1;
        end
      end else begin
        if (frame_done) begin
          rd_q      <= rx_sr;
          if (rx_valid) rx_overrun <= 1'b1;
          rx_valid  <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          bit_cnt   <= '0;
          tx_sr     <= next_tx;
          miso_o    <= next_tx[NBITS-1];
          hold_msb  <= 1'b1;
          if (tx_pending) tx_pending  <= 1'b0;
          else            tx_underrun <= 1'b1;
        end else if (sample_edge) begin
          rx_sr   <= {rx_sr[NBITS-2:0], mosi_s2};
          bit_cnt <= bit_cnt + CW'(1);
        end else if (shift_edge) begin
          if (hold_msb) begin
            miso_o   <= tx_sr[NBITS-1];
            hold_msb <= 1'b0;
          end else begin
            tx_sr  <= {tx_sr[NBITS-2:0], 1'b0};
            miso_o <= tx_sr[NBITS-2];
          end
        end

        if (csn_rise) begin
          state   <= IDLE;
          bit_cnt <= '0;
          miso_o  <= 1'b0;
          if ((bit_cnt != '0) && !frame_done) frame_error <= 1'b1;
        end
      end

      // After the frame-start logic so a load in the same cycle stays pending.
      if (load_rise) begin
        tx_hold    <= wrdata[NBITS-1:0];
        tx_pending <= 1'b1;
      end
    end
  end

  assign miso_oe = active;
  assign rddata  = 32'(rd_q);
  assign status  = {active, rx_valid, rx_overrun, tx_underrun, tx_pending,
                    frame_error, 10'd0, 2'd0, bit_cnt, frame_cnt};

endmodule

// File: tb/tb_spi_slave_top.sv
// tb_spi_slave_top
// Four spi_slave_top instances, one per SPI mode (index = {CPOL,CPHA}), each
// driven by a bit-banged master task. Words the master should receive are
// queued in exp_q when the transmit word is loaded and popped after the frame.
module tb_spi_slave_top;

  localparam int HALF = 8;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control [4];
  logic [31:0] wrdata  [4];
  logic [31:0] rddata  [4];
  logic [31:0] status  [4];
  logic        sclk    [4];
  logic        csn     [4];
  logic        mosi    [4];
  logic        miso    [4];
  logic        miso_oe [4];

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rx;
  logic [31:0] echo_w;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_top #(
      .CPOL  ((g / 2) == 1),
      .CPHA  ((g % 2) == 1),
      .NBITS (32)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .control (control[g]),
      .wrdata  (wrdata[g]),
      .rddata  (rddata[g]),
      .status  (status[g]),
      .sclk_i  (sclk[g]),
      .csn_i   (csn[g]),
      .mosi_i  (mosi[g]),
      .miso_o  (miso[g]),
      .miso_oe (miso_oe[g])
    );
  end

  // ---------------- checking ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check32(tag, got, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ctrl(input int m, input int b);
    control[m][b] = 1'b1;
    wait_clks(4);
    control[m][b] = 1'b0;
    wait_clks(4);
  endtask

  task automatic tx_load(input int m, input logic [31:0] w);
    wrdata[m] = w;
    pulse_ctrl(m, 0);
  endtask

  task automatic csn_low(input int m);
    csn[m] = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic csn_high(input int m);
    wait_clks(HALF);
    csn[m] = 1'b1;
    wait_clks(HALF);
  endtask

  // Shifts nb bits of tx (MSB first) and collects miso into got[31:32-nb].
  task automatic xfer(input int m, input logic [31:0] tx, input int nb,
                      output logic [31:0] got);
    logic cpol;
    logic cpha;
    cpol = ((m / 2) == 1);
    cpha = ((m % 2) == 1);
    got  = '0;
    for (int i = 31; i > 31 - nb; i--) begin
      if (!cpha) begin
        mosi[m] = tx[i];
        wait_clks(HALF);
        sclk[m] = ~cpol;
        got[i]  = miso[m];
        wait_clks(HALF);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = tx[i];
        wait_clks(HALF);
        sclk[m] = cpol;
        got[i]  = miso[m];
        wait_clks(HALF);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
`ifdef SPI_SLAVE_ECHO_EN
    echo_w = 32'h0F0F_0F0F;
`else
    echo_w = 32'h0000_0000;
`endif
    reset = 1'b0;
    for (int m = 0; m < 4; m++) begin
      control[m] = '0;
      wrdata[m]  = '0;
      csn[m]     = 1'b1;
      mosi[m]    = 1'b0;
      sclk[m]    = ((m / 2) == 1);
    end
    wait_clks(3);
    for (int m = 0; m < 4; m++) begin
      check32($sformatf("m%0d_reset_status", m), status[m], 32'h0);
      check32($sformatf("m%0d_reset_pins", m), {30'd0, miso[m], miso_oe[m]}, 32'h0);
    end
    reset = 1'b1;
    wait_clks(6);

    // Basic exchange in every mode.
    for (int m = 0; m < 4; m++) begin
      check32($sformatf("m%0d_idle_status", m), status[m], 32'h0);
      tx_load(m, 32'hA5A5_1234);
      exp_q.push_back(32'hA5A5_1234);
      check32($sformatf("m%0d_pending", m), status[m], 32'h0800_0000);
      csn_low(m);
      check32($sformatf("m%0d_busy", m), status[m], 32'h8000_0000);
      check32($sformatf("m%0d_oe_msb", m), {30'd0, miso_oe[m], miso[m]}, 32'h3);
      xfer(m, 32'hDEAD_BEEF, 32, rx);
      csn_high(m);
      sb_check($sformatf("m%0d_miso_word", m), rx);
      check32($sformatf("m%0d_rddata", m), rddata[m], 32'hDEAD_BEEF);
      check32($sformatf("m%0d_status", m), status[m] & 32'hEFFF_FFFF, 32'h4000_0001);
    end

    // Two words under one csn; the second load overwrites the first.
    tx_load(0, 32'hFFFF_0000);
    tx_load(0, 32'h1357_9BDF);
    exp_q.push_back(32'h1357_9BDF);
    exp_q.push_back(echo_w);
    csn_low(0);
    xfer(0, 32'h0F0F_0F0F, 32, rx);
    sb_check("b2b_word1", rx);
    xfer(0, 32'h3C3C_5A5A, 32, rx);
    sb_check("b2b_word2", rx);
    csn_high(0);
    check32("b2b_rddata", rddata[0], 32'h3C3C_5A5A);
    check32("b2b_status", status[0], 32'h7000_0003);

    // clear_flags: one register stage then edge detect.
    control[0][1] = 1'b1;
    wait_clks(1);
    check32("clear_after_1", {27'd0, status[0][30:26]}, 32'h1C);
    wait_clks(1);
    check32("clear_after_2", status[0], 32'h0000_0003);
    control[0][1] = 1'b0;
    wait_clks(4);

    // csn raised after 12 bits: partial word discarded.
    exp_q.push_back(echo_w == 32'h0 ? 32'h0 : 32'h3C30_0000);
    csn_low(0);
    xfer(0, 32'hFFFF_FFFF, 12, rx);
    check32("partial_mid_status", status[0], 32'h9000_0C03);
    sb_check("partial_miso", rx);
    csn_high(0);
    check32("partial_status", status[0], 32'h1400_0003);
    check32("partial_rddata", rddata[0], 32'h3C3C_5A5A);

    // Reset at bit 20, then a clean frame.
    tx_load(0, 32'h600D_F00D);
    exp_q.push_back(32'h600D_F000);
    csn_low(0);
    xfer(0, 32'hAAAA_AAAA, 20, rx);
    sb_check("pre_reset_miso", rx);
    reset = 1'b0;
    #1;
    check32("rst_rddata", rddata[0], 32'h0);
    check32("rst_status", status[0], 32'h0);
    check32("rst_pins", {30'd0, miso[0], miso_oe[0]}, 32'h0);
    wait_clks(3);
    reset = 1'b1;
    wait_clks(12);
    check32("rst_csn_low_idle", {status[0][31], 30'd0, miso_oe[0]}, 32'h0);
    csn[0] = 1'b1;
    wait_clks(HALF);
    tx_load(0, 32'h0BAD_CAFE);
    exp_q.push_back(32'h0BAD_CAFE);
    csn_low(0);
    xfer(0, 32'h1234_5678, 32, rx);
    csn_high(0);
    sb_check("post_rst_miso", rx);
    check32("post_rst_rddata", rddata[0], 32'h1234_5678);
    check32("post_rst_status", status[0] & 32'hEFFF_FFFF, 32'h4000_0001);

    check32("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
